// File: rtl/tdm_demux4_rx.sv
// rtl/tdm_demux4_rx.sv - 1-to-LANES serial bit demultiplexer with one-entry valid/ready output buffer
module tdm_demux4_rx #(
    parameter int LANES = 4,
    parameter int SEL_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             sync,
    output logic [LANES-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [SEL_W-1:0] slot,
    output logic             overrun,
    output logic             sync_err
);

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(LANES - 1);
    localparam logic [SEL_W-1:0] ONE_SLOT  = SEL_W'(1);

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   slot_q, slot_d;
    // The last slot bit is taken straight from din, so only LANES-1 bits are shadowed.
    logic [LANES-2:0]   shadow_q, shadow_d;
    logic [LANES-1:0]   dout_q, dout_d;
    logic               dout_valid_q, dout_valid_d;
    logic               overrun_q, overrun_d;
    logic               sync_err_q, sync_err_d;

    logic               word_done;
    logic               consume;
    logic [LANES-1:0]   word;

    assign consume = dout_valid_q && dout_ready;
    assign word    = {din, shadow_q};

    // Next-state logic: slot steering, resync handling, word completion and output buffer.
    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        shadow_d     = shadow_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        overrun_d    = 1'b0;
        sync_err_d   = 1'b0;
        word_done    = 1'b0;

        if (din_valid) begin
            case (state_q)
                IDLE: begin
                    if (sync) begin
                        shadow_d[0] = din;
                        slot_d      = ONE_SLOT;
                        state_d     = COLLECT;
                    end
                end
                COLLECT: begin
                    if (sync && (slot_q != '0)) begin
                        // Resync: the partial word is discarded and this beat restarts slot 0.
                        shadow_d[0] = din;
                        slot_d      = ONE_SLOT;
                        sync_err_d  = 1'b1;
                    end else if (slot_q == LAST_SLOT) begin
                        slot_d    = '0;
                        word_done = 1'b1;
                    end else begin
                        for (int i = 0; i < LANES - 1; i++) begin
                            if (slot_q == SEL_W'(i)) begin
                                shadow_d[i] = din;
                            end
                        end
                        slot_d = slot_q + ONE_SLOT;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (word_done) begin
            // A word may enter the buffer when it is empty or being drained this same edge.
            if (!dout_valid_q || dout_ready) begin
                dout_d       = word;
                dout_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (consume) begin
            dout_valid_d = 1'b0;
        end
    end

    // State register with synchronous reset; reset drops any partial or buffered word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            slot_q       <= '0;
            shadow_q     <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            shadow_q     <= shadow_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overrun_q    <= overrun_d;
            sync_err_q   <= sync_err_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign slot       = slot_q;
    assign overrun    = overrun_q;
    assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_tdm_demux4_rx.sv
// tb/tb_tdm_demux4_rx.sv - scoreboard bench for tdm_demux4_rx with a frame-level reference model
module tb_tdm_demux4_rx;

    localparam int LANES = 4;
    localparam int SEL_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             din;
    logic             din_valid;
    logic             sync;
    logic [LANES-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic [SEL_W-1:0] slot;
    logic             overrun;
    logic             sync_err;

    tdm_demux4_rx #(.LANES(LANES), .SEL_W(SEL_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .sync       (sync),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .slot       (slot),
        .overrun    (overrun),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             v;
        logic [LANES-1:0] d;
        logic [SEL_W-1:0] s;
        logic             ov;
        logic             se;
    } exp_t;

    exp_t             exp_q[$];
    logic [LANES-1:0] word_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: alignment flag, position within frame, received bits, buffer state.
    bit               aligned = 0;
    int               pos     = 0;
    bit               bits[LANES];
    bit               full_m  = 0;
    logic [LANES-1:0] dout_m  = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    // Drive one cycle of inputs, predict the post-edge outputs, then advance past the edge.
    task automatic step(input logic r, input logic v, input logic s, input logic d, input logic rdy);
        exp_t e;
        bit   consume;
        bit   done;
        int   w;
        rst = r; din_valid = v; sync = s; din = d; dout_ready = rdy;
        e.ov = 1'b0;
        e.se = 1'b0;
        done = 0;
        w    = 0;
        if (r) begin
            aligned = 0;
            pos     = 0;
            full_m  = 0;
            dout_m  = '0;
            foreach (bits[i]) bits[i] = 0;
            word_q.delete();
        end else begin
            consume = full_m && rdy;
            if (v) begin
                if (!aligned) begin
                    if (s) begin
                        bits[0] = d; pos = 1; aligned = 1;
                    end
                end else if (s && pos != 0) begin
                    bits[0] = d; pos = 1; e.se = 1'b1;
                end else begin
                    bits[pos] = d;
                    if (pos == LANES - 1) begin
                        for (int i = 0; i < LANES; i++) w += int'(bits[i]) * (1 << i);
                        done = 1;
                        pos  = 0;
                    end else begin
                        pos++;
                    end
                end
            end
            if (done) begin
                if (!full_m || consume) begin
                    dout_m = LANES'(w);
                    full_m = 1;
                    word_q.push_back(LANES'(w));
                end else begin
                    e.ov = 1'b1;
                end
            end else if (consume) begin
                full_m = 0;
            end
        end
        e.v = full_m;
        e.d = dout_m;
        e.s = SEL_W'(pos);
        exp_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, rdy);
    endtask

    task automatic send_frame(input logic [LANES-1:0] w, input bit s0, input int gap, input logic rdy);
        for (int i = 0; i < LANES; i++) begin
            step(1'b0, 1'b1, (s0 && i == 0), w[i], rdy);
            idle(gap, rdy);
        end
    endtask

    // Monitor: per-cycle output check plus word scoreboard popped on each handshake.
    initial begin
        exp_t             e;
        logic [LANES-1:0] w;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("dout_valid", 32'(dout_valid), 32'(e.v));
                chk("dout",       32'(dout),       32'(e.d));
                chk("slot",       32'(slot),       32'(e.s));
                chk("overrun",    32'(overrun),    32'(e.ov));
                chk("sync_err",   32'(sync_err),   32'(e.se));
            end
            if (rst === 1'b0 && dout_valid === 1'b1 && dout_ready === 1'b1) begin
                if (word_q.size() == 0) begin
                    chk("handshake_without_word", 32'(dout_valid), 32'd0);
                end else begin
                    w = word_q.pop_front();
                    chk("handshake_word", 32'(dout), 32'(w));
                end
            end
        end
    end

    initial begin
        logic [LANES-1:0] c;
        rst = 1'b1; din = 1'b0; din_valid = 1'b0; sync = 1'b0; dout_ready = 1'b0;

        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Basic frame 1101 and one-cycle latency.
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(2, 1'b0);
        idle(2, 1'b1);

        // Overrun: A held, 5 dropped.
        send_frame(4'hA, 1'b0, 0, 1'b0);
        send_frame(4'h5, 1'b0, 0, 1'b0);
        idle(3, 1'b0);
        idle(2, 1'b1);

        // Consume on the same edge a new word completes.
        send_frame(4'h3, 1'b0, 0, 1'b0);
        c = 4'hC;
        for (int i = 0; i < LANES - 1; i++) step(1'b0, 1'b1, 1'b0, c[i], 1'b0);
        step(1'b0, 1'b1, 1'b0, c[LANES-1], 1'b1);
        idle(2, 1'b0);
        idle(2, 1'b1);

        // Resync mid-frame.
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(2, 1'b1);

        // Gapped frame.
        send_frame(4'h9, 1'b0, 3, 1'b0);
        idle(1, 1'b1);

        // Reset mid-frame and with a buffered word; unsynced beats then ignored.
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(4'hF, 1'b0, 0, 1'b0);
        send_frame(4'h6, 1'b1, 0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(4'h7, 1'b0, 0, 1'b1);
        send_frame(4'hE, 1'b1, 1, 1'b1);
        idle(2, 1'b1);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 9) == 0),
                 1'($urandom),
                 ($urandom_range(0, 1) == 1));
        end

        idle(4, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 32'(word_q.size()), 32'd0);
        chk("expect_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
